// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the M stage and data memory.
// Stores are queued in order and drained through a ready handshake. Loads
// that hit a pending store get the youngest matching data forwarded.

// Word-address comparator for one buffer slot, indexed by age from head.
module sb_match #(
  parameter int AW = 32
) (
  input  logic          vld,
  input  logic [AW-3:0] ent_waddr,
  input  logic [AW-3:0] lkp_waddr,
  output logic          hit
);
  assign hit = vld && (ent_waddr == lkp_waddr);
endmodule

module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          MemWriteM,
  input  logic          MemReadM,
  input  logic [AW-1:0] ALUResultM,
  input  logic [DW-1:0] WriteDataM,
  output logic          StallSB,
  output logic          FwdHit,
  output logic [DW-1:0] FwdData,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  output logic          sb_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } sb_entry_t;

  sb_entry_t      ent [DEPTH];
  logic [PW-1:0]  head, tail;
  logic [PW:0]    count;
  logic           enq, deq;

  // A full buffer refuses the store even if a drain happens this cycle.
  assign enq       = MemWriteM && (count != FULL);
  assign deq       = mem_we && mem_ready;
  assign StallSB   = MemWriteM && (count == FULL);
  assign mem_we    = (count != '0);
  assign sb_empty  = (count == '0);
  assign mem_addr  = ent[head].addr;
  assign mem_wdata = ent[head].data;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!clr) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are meaningless outside head..tail-1.
  always_ff @(posedge clk) begin
    if (enq) ent[tail] <= '{addr: ALUResultM, data: WriteDataM};
  end

  // Slots are examined by age (distance from head) so wrap does not
  // disturb which match counts as youngest.
  logic [DEPTH-1:0]         age_vld, age_hit;
  logic [DEPTH-1:0][DW-1:0] age_data;

  for (genvar k = 0; k < DEPTH; k++) begin : g_age
    logic [PW-1:0] idx;
    assign idx         = head + PW'(k);
    assign age_vld[k]  = (PW+1)'(k) < count;
    assign age_data[k] = ent[idx].data;
    sb_match #(.AW(AW)) u_match (
      .vld       (age_vld[k]),
      .ent_waddr (ent[idx].addr[AW-1:2]),
      .lkp_waddr (ALUResultM[AW-1:2]),
      .hit       (age_hit[k])
    );
  end

  // Youngest-match select: later (older-to-younger) hits override earlier.
  always_comb begin
    FwdHit  = 1'b0;
    FwdData = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (MemReadM && age_hit[k]) begin
        FwdHit  = 1'b1;
        FwdData = age_data[k];
      end
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: a queue of accepted stores acts as the reference
// for drain order, occupancy, stall and forwarding.
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        clr, MemWriteM, MemReadM, mem_ready;
  logic [31:0] ALUResultM, WriteDataM;
  logic        StallSB, FwdHit, mem_we, sb_empty;
  logic [31:0] FwdData, mem_addr, mem_wdata;

  store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk(clk), .clr(clr), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .StallSB(StallSB),
    .FwdHit(FwdHit), .FwdData(FwdData), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .sb_empty(sb_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  int   n_tests = 0, n_fail = 0;
  int   n_dut_wr = 0;
  logic any_stall;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle: drive, check comb outputs against the queue, advance model.
  task automatic step(input logic we, input logic re, input logic rdy,
                      input logic rst_n, input logic [31:0] a,
                      input logic [31:0] d, output logic acc);
    logic        hit;
    logic [31:0] fd;
    ent_t        e;
    int          sz;
    MemWriteM = we; MemReadM = re; mem_ready = rdy; clr = rst_n;
    ALUResultM = a; WriteDataM = d;
    #1;
    sz = q.size();
    chk("stall", StallSB, we && (sz == DEPTH));
    chk("empty", sb_empty, sz == 0);
    chk("mem_we", mem_we, sz != 0);
    if (sz != 0) begin
      chk("mem_addr", mem_addr, q[0].addr);
      chk("mem_wdata", mem_wdata, q[0].data);
    end
    hit = 1'b0; fd = 32'h0;
    if (re)
      for (int i = 0; i < sz; i++)
        if (q[i].addr[31:2] == a[31:2]) begin hit = 1'b1; fd = q[i].data; end
    chk("fwd_hit", FwdHit, hit);
    chk("fwd_data", FwdData, fd);
    if (StallSB) any_stall = 1'b1;
    if (mem_we && rdy) n_dut_wr++;
    acc = we && rst_n && (sz < DEPTH);
    @(posedge clk);
    if (!rst_n) q.delete();
    else begin
      if (sz != 0 && rdy) void'(q.pop_front());
      if (acc) begin e.addr = a; e.data = d; q.push_back(e); end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 20 && q.size() != 0; i++) step(0, 0, 1, 1, 0, 0, acc);
    chk("drained", sb_empty, 1'b1);
  endtask

  initial begin
    logic acc;
    int   wr0;
    clr = 1'b0; MemWriteM = 0; MemReadM = 0; mem_ready = 0;
    ALUResultM = 0; WriteDataM = 0;
    @(posedge clk); @(negedge clk);
    // reset state
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_empty", sb_empty, 1'b1);
    chk("rst_stall", StallSB, 1'b0);
    chk("rst_fwd", FwdHit, 1'b0);
    step(0, 0, 0, 1, 0, 0, acc);

    // single store, drains on the next cycle
    step(1, 0, 1, 1, 32'h100, 32'hDEADBEEF, acc);
    chk("single_we", mem_we, 1'b1);
    chk("single_addr", mem_addr, 32'h100);
    step(0, 0, 1, 1, 0, 0, acc);
    chk("single_empty", sb_empty, 1'b1);

    // fill, then stall on the fifth
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 32'(i*4), 32'hA0 + 32'(i), acc);
    step(1, 0, 0, 1, 32'h10, 32'hA4, acc);
    step(1, 0, 0, 1, 32'h10, 32'hA4, acc);
    #1 chk("stall5", StallSB, 1'b1);
    chk("stall5_head", mem_addr, 32'h0);
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) step(1, 0, 1, 1, 32'h10, 32'hA4, acc);
    chk("stall5_accepted", acc, 1'b1);
    drain();

    // forwarding picks the youngest match
    step(1, 0, 0, 1, 32'h20, 32'h11, acc);
    step(1, 0, 0, 1, 32'h24, 32'h22, acc);
    step(1, 0, 0, 1, 32'h20, 32'h33, acc);
    MemReadM = 1; ALUResultM = 32'h22; MemWriteM = 0; #1;
    chk("fwd_young_hit", FwdHit, 1'b1);
    chk("fwd_young_data", FwdData, 32'h33);
    step(0, 1, 0, 1, 32'h22, 0, acc);
    step(0, 1, 0, 1, 32'h28, 0, acc);
    // load and store together: the new store is not a source
    step(1, 1, 0, 1, 32'h24, 32'h44, acc);
    MemReadM = 1; MemWriteM = 0; ALUResultM = 32'h24; #1;
    chk("fwd_after_same", FwdData, 32'h44);
    drain();

    // steady streaming with mem_ready held high
    any_stall = 1'b0; wr0 = n_dut_wr;
    for (int i = 0; i < 10; i++)
      step(1, i > 0, 1, 1, 32'h200 + 32'(i*4), 32'hC0 + 32'(i),
           acc);
    chk("steady_one", q.size() == 1 && !sb_empty, 1'b1);
    drain();
    chk("steady_writes", n_dut_wr - wr0, 10);
    chk("steady_nostall", any_stall, 1'b0);

    // forwarding across a wrapped pointer
    step(1, 0, 0, 1, 32'h40, 32'h1, acc);
    step(1, 0, 0, 1, 32'h44, 32'h2, acc);
    step(1, 0, 0, 1, 32'h40, 32'h3, acc);
    step(1, 0, 0, 1, 32'h48, 32'h4, acc);
    step(0, 1, 0, 1, 32'h41, 0, acc);
    step(0, 1, 1, 1, 32'h40, 0, acc);
    drain();

    // random traffic over a small address set
    for (int i = 0; i < 200; i++)
      step(1'($urandom % 2), 1'($urandom % 2), ($urandom % 3) == 0, 1,
           32'h300 + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(0, 3)),
           $urandom, acc);
    drain();

    // reset with three pending stores
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 32'h500 + 32'(i*4), 32'(i), acc);
    step(0, 0, 0, 0, 0, 0, acc);
    chk("rst_mid_we", mem_we, 1'b0);
    chk("rst_mid_empty", sb_empty, 1'b1);
    wr0 = n_dut_wr;
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 0, 0, acc);
    chk("rst_mid_nowrite", n_dut_wr - wr0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
